// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_if
//  Description : Data-memory bus port of the interrupt controller
//                (single-cycle strobes, registered read data).
//  Revision    : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_we,
        output bus_re,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_we,
        input  bus_re,
        output bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Level-triggered platform interrupt controller with per-source
//                gateways, enable mask and claim/complete register.
//                Optional macro IRQ_SYNC_EN adds a 2-flop input synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int NSRC = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic [NSRC-1:0] irq_src,
    irq_ctrl_if.slave            bus,
    output logic                 external_int
);

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_INSERV  = 2'd3;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_t;

    logic [NSRC-1:0] w_src;
    logic [NSRC-1:0] w_pending;
    logic [NSRC-1:0] w_claimed;
    logic [NSRC-1:0] w_cand;
    logic [NSRC-1:0] w_claim_oh;
    logic [4:0]      w_claim_id;
    logic [1:0]      w_sel;
    logic            w_wr;
    logic            w_rd;
    logic            w_claim_rd;
    logic            w_cmpl_wr;
    logic [4:0]      w_cmpl_id;
    logic [31:0]     w_rmux;
    logic            w_unused;

    logic [NSRC-1:0] enable_q;
    logic [31:0]     rdata_q;
    logic            ext_q;

    // ------------------------------------------------------------------------
    // Source conditioning
    // ------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] sync1_q;
    logic [NSRC-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign w_src = sync2_q;
`else
    assign w_src = irq_src;
`endif

    // ------------------------------------------------------------------------
    // Bus decode; a simultaneous read and write keeps only the write
    // ------------------------------------------------------------------------
    assign w_sel      = bus.bus_addr[3:2];
    assign w_wr       = bus.bus_we;
    assign w_rd       = bus.bus_re & ~bus.bus_we;
    assign w_claim_rd = w_rd && (w_sel == REG_CLAIM);
    assign w_cmpl_wr  = w_wr && (w_sel == REG_CLAIM);
    assign w_cmpl_id  = bus.bus_wdata[4:0];

    // Byte-lane bits of the address and the wide data bits are architecturally ignored
    assign w_unused = ^{bus.bus_addr[1:0], bus.bus_wdata};

    // ------------------------------------------------------------------------
    // Per-source gateways
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NSRC; i++) begin : g_gw
        gw_state_t state_q;
        gw_state_t state_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= GW_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                GW_IDLE: begin
                    if (w_src[i]) begin
                        state_d = GW_PENDING;
                    end
                end
                GW_PENDING: begin
                    if (w_claim_rd && w_claim_oh[i]) begin
                        state_d = GW_CLAIMED;
                    end
                end
                GW_CLAIMED: begin
                    if (w_cmpl_wr && (w_cmpl_id == 5'(i + 1))) begin
                        state_d = GW_IDLE;
                    end
                end
                default: state_d = GW_IDLE;
            endcase
        end

        assign w_pending[i] = (state_q == GW_PENDING);
        assign w_claimed[i] = (state_q == GW_CLAIMED);
    end

    // ------------------------------------------------------------------------
    // Fixed-priority arbiter: scanning downwards leaves the lowest index last
    // ------------------------------------------------------------------------
    assign w_cand = w_pending & enable_q;

    always_comb begin
        w_claim_id = '0;
        w_claim_oh = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_claim_id    = 5'(i + 1);
                w_claim_oh    = '0;
                w_claim_oh[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read data mux
    // ------------------------------------------------------------------------
    always_comb begin
        w_rmux = '0;
        case (w_sel)
            REG_PENDING: w_rmux = {{(32 - NSRC){1'b0}}, w_pending};
            REG_ENABLE:  w_rmux = {{(32 - NSRC){1'b0}}, enable_q};
            REG_CLAIM:   w_rmux = {27'd0, w_claim_id};
            REG_INSERV:  w_rmux = {{(32 - NSRC){1'b0}}, w_claimed};
            default:     w_rmux = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= '0;
        end else if (w_wr && (w_sel == REG_ENABLE)) begin
            enable_q <= bus.bus_wdata[NSRC-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (w_rd) begin
            rdata_q <= w_rmux;
        end
    end

    // Driven from registered gateway/enable state, hence one cycle behind PENDING
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q <= 1'b0;
        end else begin
            ext_q <= |(w_pending & enable_q);
        end
    end

    assign bus.bus_rdata = rdata_q;
    assign external_int  = ext_q;

endmodule
`default_nettype wire
